frame_scheduler: RTL and testbench

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

---
 rtl/mfcc_pkg.sv | 18 +
 rtl/frame_buffer.sv | 25 ++
 rtl/frame_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_frame_scheduler.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mfcc_pkg.sv
// Shared MFCC front-end constants and the frame scheduler state encoding.
// Used by the frame scheduler and the downstream window/FFT blocks.
package mfcc_pkg;

    localparam int DW  = 16;   // Q15 sample width
    localparam int N   = 256;  // samples per analysis frame
    localparam int HOP = 128;  // frame advance
    localparam int NF  = 512;  // zero-padded FFT length
    localparam int BUF = 512;  // circular sample buffer depth

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2,
        PAD  = 2'd3
    } state_t;

endpackage

// File: rtl/frame_buffer.sv
// Circular sample store: one synchronous write port, one asynchronous read port.
// Read data is combinational and reflects contents before a same-cycle write.
module frame_buffer #(
    parameter int DW    = 16,
    parameter int DEPTH = 512
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [DW-1:0]            wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [DW-1:0]            rd_data_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/frame_scheduler.sv
// Cuts the input stream into overlapping N-sample frames, zero-padded to NF beats.
// First beat 1 cycle after the Nth write; output register holds while stalled by out_ready.
module frame_scheduler #(
    parameter int DW  = mfcc_pkg::DW,
    parameter int N   = mfcc_pkg::N,
    parameter int HOP = mfcc_pkg::HOP,
    parameter int NF  = mfcc_pkg::NF,
    parameter int BUF = mfcc_pkg::BUF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DW-1:0]         sample_in,
    input  logic                  sample_valid,
    output logic [DW-1:0]         out_sample,
    output logic [$clog2(NF)-1:0] out_index,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_pad,
    output logic                  frame_start,
    output logic                  frame_end,
    output logic [15:0]           frame_count,
    output logic                  overrun
);

    import mfcc_pkg::*;

    localparam int AW = $clog2(BUF);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(NF);

    localparam logic [CW-1:0] N_CNT    = CW'(N);
    localparam logic [CW-1:0] HOP_CNT  = CW'(HOP);
    localparam logic [CW-1:0] BUF_CNT  = CW'(BUF);
    localparam logic [IW:0]   N_IDX    = (IW+1)'(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(NF - 1);

    state_t          state_q;
    logic [CW-1:0]   wr_count_q;
    logic [CW-1:0]   base_q;
    logic [DW-1:0]   out_sample_q;
    logic [IW-1:0]   out_index_q;
    logic            out_valid_q;
    logic            out_pad_q;
    logic            frame_start_q;
    logic            frame_end_q;
    logic [15:0]     frame_count_q;
    logic            overrun_q;

    logic [CW-1:0]   avail;
    logic            buf_full;
    logic            wr_accept;
    logic            handshake;
    logic [IW:0]     idx_next;
    logic [IW-1:0]   rd_idx;
    logic [AW-1:0]   rd_addr;
    logic [DW-1:0]   rd_data;

    // avail never exceeds BUF because writes stop at full
    assign avail     = wr_count_q - base_q;
    assign buf_full  = (avail == BUF_CNT);
    assign wr_accept = sample_valid && enable && (state_q != IDLE) && !buf_full;
    assign handshake = out_valid_q && out_ready;
    assign idx_next  = {1'b0, out_index_q} + (IW+1)'(1);

    // FILL fetches the frame's first sample; otherwise prefetch the next index
    assign rd_idx  = (state_q == FILL) ? '0 : idx_next[IW-1:0];
    assign rd_addr = base_q[AW-1:0] + AW'(rd_idx);

    frame_buffer #(
        .DW    (DW),
        .DEPTH (BUF)
    ) u_frame_buffer (
        .clk_i     (clk),
        .wr_en_i   (wr_accept),
        .wr_addr_i (wr_count_q[AW-1:0]),
        .wr_data_i (sample_in),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_count_q    <= '0;
            base_q        <= '0;
            out_sample_q  <= '0;
            out_index_q   <= '0;
            out_valid_q   <= 1'b0;
            out_pad_q     <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_count_q <= '0;
            overrun_q     <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_count_q <= wr_count_q + CW'(1);
            end
            if (sample_valid && buf_full) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    wr_count_q    <= '0;
                    base_q        <= '0;
                    frame_count_q <= '0;
                    if (enable) begin
                        state_q <= FILL;
                    end
                end

                FILL: begin
                    if (!enable) begin
                        state_q       <= IDLE;
                        wr_count_q    <= '0;
                        base_q        <= '0;
                        frame_count_q <= '0;
                    end else if (avail >= N_CNT) begin
                        out_sample_q  <= rd_data;
                        out_index_q   <= '0;
                        out_valid_q   <= 1'b1;
                        out_pad_q     <= 1'b0;
                        frame_start_q <= 1'b1;
                        frame_end_q   <= (LAST_IDX == '0);
                        state_q       <= EMIT;
                    end
                end

                EMIT, PAD: begin
                    if (handshake) begin
                        if (out_index_q == LAST_IDX) begin
                            // frame done: slide the window and leave a bubble
                            base_q        <= base_q + HOP_CNT;
                            frame_count_q <= frame_count_q + 16'd1;
                            out_valid_q   <= 1'b0;
                            out_sample_q  <= '0;
                            out_index_q   <= '0;
                            out_pad_q     <= 1'b0;
                            frame_start_q <= 1'b0;
                            frame_end_q   <= 1'b0;
                            if (enable) begin
                                state_q <= FILL;
                            end else begin
                                state_q       <= IDLE;
                                wr_count_q    <= '0;
                                base_q        <= '0;
                                frame_count_q <= '0;
                            end
                        end else if (idx_next < N_IDX) begin
                            out_sample_q  <= rd_data;
                            out_index_q   <= idx_next[IW-1:0];
                            out_pad_q     <= 1'b0;
                            frame_start_q <= 1'b0;
                            frame_end_q   <= 1'b0;
                            state_q       <= EMIT;
                        end else begin
                            out_sample_q  <= '0;
                            out_index_q   <= idx_next[IW-1:0];
                            out_pad_q     <= 1'b1;
                            frame_start_q <= 1'b0;
                            frame_end_q   <= (idx_next[IW-1:0] == LAST_IDX);
                            state_q       <= PAD;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_sample  = out_sample_q;
    assign out_index   = out_index_q;
    assign out_valid   = out_valid_q;
    assign out_pad     = out_pad_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign frame_count = frame_count_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler: ramps, stalls, overrun, enable drop and reset.
module tb_frame_scheduler;

    import mfcc_pkg::*;

    localparam int IW = $clog2(NF);

    logic              clk;
    logic              rst;
    logic              enable;
    logic [DW-1:0]     sample_in;
    logic              sample_valid;
    logic [DW-1:0]     out_sample;
    logic [IW-1:0]     out_index;
    logic              out_valid;
    logic              out_ready;
    logic              out_pad;
    logic              frame_start;
    logic              frame_end;
    logic [15:0]       frame_count;
    logic              overrun;

    int                n_checks = 0;
    int                n_pass   = 0;
    int                exp_frame;
    int                exp_idx;
    int                frames_done;
    bit                pending_fc;
    int                first_valid_cyc;
    int                last_wr_cyc;
    logic [15:0]       lfsr;
    logic [DW-1:0]     stim_q[$];

    frame_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .out_sample   (out_sample),
        .out_index    (out_index),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pad      (out_pad),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .frame_count  (frame_count),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] snap();
        return 32'({out_valid, out_pad, frame_start, frame_end, out_index, out_sample});
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_outs"}, 32'({out_valid, out_pad, frame_start, frame_end, overrun,
                                  out_index, out_sample}), 32'd0);
        check({tag, "_fc"}, 32'(frame_count), 32'd0);
    endtask

    task automatic fill_ramp(input int first, input int n);
        for (int i = 0; i < n; i++) stim_q.push_back(DW'(first + i));
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        out_ready    = 1'b0;
        stim_q.delete();
        step();
        step();
        check_reset("reset");
        rst        = 1'b0;
        exp_frame  = 0;
        exp_idx    = 0;
        pending_fc = 0;
        step();
        enable = 1'b1;
        step();
    endtask

    // mode 0: ready high, 1: pseudo-random ready, 2: ready low
    task automatic run(input int n_wr, input int gap, input int mode, input int frames_goal,
                       input int drop_at, input int abort_at, input int max_cyc);
        int            wr_left;
        int            t;
        bit            done;
        bit            hit_abort;
        bit            prev_stall;
        logic [31:0]   prev_snap;
        logic [DW-1:0] exp_s;
        wr_left         = n_wr;
        frames_done     = 0;
        prev_stall      = 0;
        prev_snap       = '0;
        first_valid_cyc = -1;
        last_wr_cyc     = -1;
        t               = 0;
        done            = 0;
        while (!done && t < max_cyc) begin
            if (wr_left == 0 && frames_done >= frames_goal && !pending_fc) begin
                done = 1;
            end else begin
                hit_abort = 0;
                if (wr_left > 0 && (t % gap) == 0) begin
                    sample_valid = 1'b1;
                    sample_in    = stim_q.pop_front();
                    wr_left--;
                    if (wr_left == 0) last_wr_cyc = t;
                end else begin
                    sample_valid = 1'b0;
                end
                case (mode)
                    0: out_ready = 1'b1;
                    1: begin
                        out_ready = lfsr[0];
                        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                    end
                    default: out_ready = 1'b0;
                endcase

                if (pending_fc) begin
                    check("frame_count", 32'(frame_count), enable ? 32'(exp_frame) : 32'd0);
                    check("bubble", 32'(out_valid), 32'd0);
                    pending_fc = 0;
                end
                if (prev_stall) check("stall_hold", snap(), prev_snap);
                if (out_valid && first_valid_cyc < 0) first_valid_cyc = t;
                if (out_valid && out_ready) begin
                    exp_s = (exp_idx < N) ? DW'(exp_frame * HOP + exp_idx) : '0;
                    check("index", 32'(out_index), 32'(exp_idx));
                    check("data", 32'(out_sample), 32'(exp_s));
                    check("pad", 32'(out_pad), 32'(exp_idx >= N));
                    check("start", 32'(frame_start), 32'(exp_idx == 0));
                    check("end", 32'(frame_end), 32'(exp_idx == NF - 1));
                    if (exp_idx == drop_at) enable = 1'b0;
                    if (exp_idx == abort_at) hit_abort = 1;
                    exp_idx++;
                    if (exp_idx == NF) begin
                        exp_idx = 0;
                        exp_frame++;
                        frames_done++;
                        pending_fc = 1;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_snap  = snap();
                if (hit_abort) begin
                    done = 1;
                end else begin
                    step();
                    t++;
                end
            end
        end
        if (!done) check("run_done", 32'(done), 32'd1);
        sample_valid = 1'b0;
    endtask

    initial begin
        int vcount;
        rst          = 1'b1;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        out_ready    = 1'b0;
        lfsr         = 16'hACE1;

        // single frame from a 256-sample ramp
        do_reset();
        fill_ramp(0, 256);
        run(256, 1, 0, 1, -1, -1, 2000);
        // write driven in cycle c lands on edge c+1; first beat must be visible after edge c+2
        check("first_latency", 32'(first_valid_cyc - last_wr_cyc), 32'd2);

        // overlapping frames from a paced 640-sample ramp
        do_reset();
        fill_ramp(0, 640);
        run(640, 3, 0, 4, -1, -1, 4000);
        check("paced_no_overrun", 32'(overrun), 32'd0);

        // random backpressure
        do_reset();
        fill_ramp(0, 256);
        run(256, 1, 1, 1, -1, -1, 3000);

        // overrun: 512 fit, the 513th is dropped
        do_reset();
        fill_ramp(0, 512);
        run(512, 1, 2, 0, -1, -1, 600);
        check("ovr_before", 32'(overrun), 32'd0);
        stim_q.push_back(16'hDEAD);
        run(1, 1, 2, 0, -1, -1, 10);
        step();
        check("ovr_set", 32'(overrun), 32'd1);
        run(0, 1, 0, 3, -1, -1, 2000);
        check("ovr_sticky", 32'(overrun), 32'd1);
        fill_ramp(512, 128);
        run(128, 1, 0, 1, -1, -1, 1000);
        check("ovr_fc", 32'(frame_count), 32'd4);

        // enable dropped at index 100
        do_reset();
        fill_ramp(0, 256);
        run(256, 1, 0, 1, 100, -1, 2000);
        vcount       = 0;
        sample_valid = 1'b1;
        out_ready    = 1'b1;
        repeat (50) begin
            if (out_valid) vcount++;
            step();
        end
        sample_valid = 1'b0;
        check("idle_no_valid", 32'(vcount), 32'd0);
        check("idle_fc", 32'(frame_count), 32'd0);

        // reset mid-frame, then a fresh ramp
        do_reset();
        fill_ramp(0, 256);
        run(256, 1, 0, 1, -1, 50, 2000);
        rst = 1'b1;
        step();
        check_reset("reset_mid");
        do_reset();
        fill_ramp(0, 256);
        run(256, 1, 0, 1, -1, -1, 2000);
        check("rerun_latency", 32'(first_valid_cyc - last_wr_cyc), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
